// File: rtl/cpu_trace_checker.sv
// Character-stream checker for CPU write-back trace lines.
// Parses register/memory write lines one ASCII char per clock, applies
// register-range, alignment and timestamp checks, and counts good lines.
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | waiting for '^'
// S_CARET  | '^' seen, expecting first time digit
// S_TIME   | collecting decimal time digits
// S_AT     | '@' seen, expecting first pc hex digit
// S_PC     | collecting pc hex digits
// S_COLON  | ':' seen, spaces then '$' or '*'
// S_DOLLAR | '$' seen, expecting first register digit
// S_GRF    | collecting register digits
// S_STAR   | '*' seen, expecting first addr hex digit
// S_ADDR   | collecting addr hex digits
// S_SP     | spaces before '<'
// S_LT     | '<' seen, expecting '='
// S_EQ     | '=' seen, spaces then data
// S_DATA   | collecting data hex digits
// S_DONE   | '#' accepted, outputs valid for this cycle
module cpu_trace_checker #(
  parameter int TIME_DIGITS = 4,
  parameter int GRF_DIGITS  = 4,
  parameter int HEX_DIGITS  = 8,
  parameter int GRF_MAX     = 31,
  parameter int ALLOW_UPPER = 0,
  parameter int CHECK_TIME  = 1,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                char,
  output logic [1:0]                format_type,
  output logic [2:0]                err_code,
  output logic [4*TIME_DIGITS-1:0]  time_out,
  output logic [4*HEX_DIGITS-1:0]   pc_out,
  output logic [CNT_W-1:0]          line_cnt
);

  localparam int TW   = 4 * TIME_DIGITS;
  localparam int GW   = 4 * GRF_DIGITS;
  localparam int HW   = 4 * HEX_DIGITS;
  localparam int MAXD = (HEX_DIGITS > TIME_DIGITS)
                        ? ((HEX_DIGITS > GRF_DIGITS) ? HEX_DIGITS : GRF_DIGITS)
                        : ((TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS);
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_DOLLAR, S_GRF,
    S_STAR, S_ADDR, S_SP, S_LT, S_EQ, S_DATA, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   time_acc_q, time_acc_d;
  logic [GW-1:0]   grf_acc_q, grf_acc_d;
  logic [HW-1:0]   pc_q, pc_d;
  logic [HW-1:0]   addr_q, addr_d;
  logic            is_mem_q, is_mem_d;
  logic [2:0]      err_q, err_d;
  logic [TW-1:0]   prev_time_q, prev_time_d;
  logic [TW-1:0]   time_out_q, time_out_d;
  logic [HW-1:0]   pc_out_q, pc_out_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;

  logic       is_dig, is_hex;
  logic [3:0] hex_val;
  logic [2:0] err_new;

  // Character classification; a-f/A-F have low nibble 1..6, so +9 gives 10..15.
  always_comb begin
    is_dig  = (char >= "0") && (char <= "9");
    is_hex  = is_dig || ((char >= "a") && (char <= "f")) ||
              ((ALLOW_UPPER != 0) && (char >= "A") && (char <= "F"));
    hex_val = is_dig ? char[3:0] : (char[3:0] + 4'd9);
  end

  // Error code for the line being closed; lowest nonzero code wins.
  always_comb begin
    if (!is_mem_q && (grf_acc_q > GW'(GRF_MAX)))                 err_new = 3'd1;
    else if (pc_q[1:0] != 2'b00)                                 err_new = 3'd2;
    else if (is_mem_q && (addr_q[1:0] != 2'b00))                 err_new = 3'd3;
    else if ((CHECK_TIME != 0) && (time_acc_q < prev_time_q))    err_new = 3'd4;
    else                                                         err_new = 3'd0;
  end

  // Next-state, field capture and line completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    time_acc_d  = time_acc_q;
    grf_acc_d   = grf_acc_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    is_mem_d    = is_mem_q;
    err_d       = err_q;
    prev_time_d = prev_time_q;
    time_out_d  = time_out_q;
    pc_out_d    = pc_out_q;
    line_cnt_d  = line_cnt_q;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_CARET: begin
        if (is_dig) begin
          state_d = S_TIME; time_acc_d = TW'(hex_val); cnt_d = CW'(1);
        end else state_d = S_IDLE;
      end
      S_TIME: begin
        if (is_dig && (cnt_q < CW'(TIME_DIGITS))) begin
          time_acc_d = time_acc_q * TW'(10) + TW'(hex_val); cnt_d = cnt_q + CW'(1);
        end else if (char == "@") state_d = S_AT;
        else state_d = S_IDLE;
      end
      S_AT: begin
        if (is_hex) begin
          state_d = S_PC; pc_d = {pc_q[HW-5:0], hex_val}; cnt_d = CW'(1);
        end else state_d = S_IDLE;
      end
      S_PC: begin
        if (is_hex && (cnt_q < CW'(HEX_DIGITS))) begin
          pc_d = {pc_q[HW-5:0], hex_val}; cnt_d = cnt_q + CW'(1);
        end else if ((char == ":") && (cnt_q == CW'(HEX_DIGITS))) state_d = S_COLON;
        else state_d = S_IDLE;
      end
      S_COLON: begin
        if (char == " ")      state_d = S_COLON;
        else if (char == "$") begin state_d = S_DOLLAR; is_mem_d = 1'b0; end
        else if (char == "*") begin state_d = S_STAR;   is_mem_d = 1'b1; end
        else                  state_d = S_IDLE;
      end
      S_DOLLAR: begin
        if (is_dig) begin
          state_d = S_GRF; grf_acc_d = GW'(hex_val); cnt_d = CW'(1);
        end else state_d = S_IDLE;
      end
      S_GRF: begin
        if (is_dig && (cnt_q < CW'(GRF_DIGITS))) begin
          grf_acc_d = grf_acc_q * GW'(10) + GW'(hex_val); cnt_d = cnt_q + CW'(1);
        end else if (char == " ") state_d = S_SP;
        else if (char == "<")     state_d = S_LT;
        else                      state_d = S_IDLE;
      end
      S_STAR: begin
        if (is_hex) begin
          state_d = S_ADDR; addr_d = {addr_q[HW-5:0], hex_val}; cnt_d = CW'(1);
        end else state_d = S_IDLE;
      end
      S_ADDR: begin
        if (is_hex && (cnt_q < CW'(HEX_DIGITS))) begin
          addr_d = {addr_q[HW-5:0], hex_val}; cnt_d = cnt_q + CW'(1);
        end else if ((char == " ") && (cnt_q == CW'(HEX_DIGITS))) state_d = S_SP;
        else if ((char == "<") && (cnt_q == CW'(HEX_DIGITS)))     state_d = S_LT;
        else state_d = S_IDLE;
      end
      S_SP: begin
        if (char == " ")      state_d = S_SP;
        else if (char == "<") state_d = S_LT;
        else                  state_d = S_IDLE;
      end
      S_LT: state_d = (char == "=") ? S_EQ : S_IDLE;
      S_EQ: begin
        if (char == " ")  state_d = S_EQ;
        else if (is_hex) begin state_d = S_DATA; cnt_d = CW'(1); end
        else              state_d = S_IDLE;
      end
      S_DATA: begin
        if (is_hex && (cnt_q < CW'(HEX_DIGITS))) begin
          cnt_d = cnt_q + CW'(1);
        end else if ((char == "#") && (cnt_q == CW'(HEX_DIGITS))) begin
          state_d    = S_DONE;
          err_d      = err_new;
          time_out_d = time_acc_q;
          pc_out_d   = pc_q;
          if (err_new == 3'd0) begin
            prev_time_d = time_acc_q;
            if (line_cnt_q != {CNT_W{1'b1}}) line_cnt_d = line_cnt_q + CNT_W'(1);
          end
        end else state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // '^' restarts a line from any state, discarding partial fields.
    if (char == "^") begin
      state_d    = S_CARET;
      cnt_d      = '0;
      time_acc_d = '0;
      grf_acc_d  = '0;
      pc_d       = '0;
      addr_d     = '0;
      is_mem_d   = 1'b0;
    end
  end

  // State and field registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      time_acc_q  <= '0;
      grf_acc_q   <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      is_mem_q    <= 1'b0;
      err_q       <= '0;
      prev_time_q <= '0;
      time_out_q  <= '0;
      pc_out_q    <= '0;
      line_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      time_acc_q  <= time_acc_d;
      grf_acc_q   <= grf_acc_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      is_mem_q    <= is_mem_d;
      err_q       <= err_d;
      prev_time_q <= prev_time_d;
      time_out_q  <= time_out_d;
      pc_out_q    <= pc_out_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  // Moore outputs of DONE; the async reset of state_q zeroes them immediately.
  always_comb begin
    format_type = 2'b00;
    err_code    = 3'd0;
    if (state_q == S_DONE) begin
      err_code    = err_q;
      format_type = (err_q != 3'd0) ? 2'b11 : (is_mem_q ? 2'b10 : 2'b01);
    end
  end

  assign time_out = time_out_q;
  assign pc_out   = pc_out_q;
  assign line_cnt = line_cnt_q;

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Parametrised character-stream checker for CPU write-back trace lines. Consumes one ASCII character per clock.
- Classifies each completed line as a register write or a memory write.
- Adds semantic checks on top of the syntax check: register index range, word alignment of PC and address, and monotonic timestamps.
- Captures the fields of the last completed line and keeps a running count of good lines.
- Sits beside the CPU under test in simulation/FPGA benches, fed by the trace UART/monitor byte stream.

Parameters:
- TIME_DIGITS, 4, max decimal digits in time field (1..TIME_DIGITS accepted)
- GRF_DIGITS, 4, max decimal digits in register field
- HEX_DIGITS, 8, exact hex digit count of pc, addr and data fields
- GRF_MAX, 31, highest legal register index
- ALLOW_UPPER, 0, 1 = hex digits A-F also accepted
- CHECK_TIME, 1, 1 = flag a line whose time is less than the previous good line's time
- CNT_W, 16, width of good-line counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- char  in  8  ASCII character, sampled every rising edge
- format_type  out  2  00 none, 01 reg write ok, 10 mem write ok, 11 syntax ok but semantic error
- err_code  out  3  0 none, 1 grf>GRF_MAX, 2 pc[1:0]!=0, 3 addr[1:0]!=0, 4 time decreased
- time_out  out  4*TIME_DIGITS  binary time of last syntactically complete line
- pc_out  out  4*HEX_DIGITS  pc of last syntactically complete line
- line_cnt  out  CNT_W  count of lines that ended with format_type 01/10, saturating

Behaviour:
- Accepted grammar, all tokens case-sensitive:
  - Register write: `^ T @ P : S* $ G S* < = S* D #`
  - Memory write: `^ T @ P : S* * A S* < = S* D #`
  - T = 1..TIME_DIGITS decimal digits; leading zeros allowed.
  - G = 1..GRF_DIGITS decimal digits.
  - P, A, D = exactly HEX_DIGITS hex digits: 0-9a-f, plus A-F when ALLOW_UPPER=1.
  - S = space.
- States: IDLE, CARET, TIME, AT, PC, COLON, DOLLAR, GRF, STAR, ADDR, SP, LT, EQ, DATA, DONE.
- Any unexpected character → IDLE. This includes a digit beyond its field's max count and a delimiter arriving before the exact hex count is reached.
- `^` in any state → CARET. All field counters and accumulators clear.
- Field capture:
  - time_acc = time_acc*10+digit and grf_acc = grf_acc*10+digit, each width 4*N bits.
  - pc/addr are shifted in 4 bits per digit, MSB first.
- Entering DONE (on the edge that samples `#`):
  - Compute the error code. Lowest nonzero code wins:
    - 1 if reg line and grf_acc>GRF_MAX
    - 2 if pc[1:0]!=0
    - 3 if mem line and addr[1:0]!=0
    - 4 if CHECK_TIME and time_acc<prev_time
  - time_out/pc_out are loaded with the captured fields. They hold until the next DONE entry.
  - If err==0: prev_time<=time_acc and line_cnt increments, holding at all-ones.
- format_type and err_code are Moore outputs of DONE. Outside DONE: format_type=00, err_code=0.
  - Nonzero for exactly one cycle, the cycle after `#` is sampled, unless char in that cycle is `^`. In that case they are still valid that cycle and the FSM goes to CARET.
- DONE exits: `^` → CARET, anything else → IDLE. A second `#` gives no repeat pulse.
- Asynchronous reset (low), including mid-line:
  - FSM → IDLE; all accumulators, prev_time, time_out, pc_out and line_cnt → 0.
  - format_type=00, err_code=0 immediately, without waiting for a clock edge.
  - The partial line is discarded.
- Reset release needs no warm-up; the first char is sampled on the next edge.

Test Plan:
- `^12@00003000: $4 <= 0000000a#` → one cycle format_type=01, err_code=0, time_out=12, pc_out=0x00003000, line_cnt=1.
- `^13@00003004:   *00001008  <=deadbeef#` after the previous line → format_type=10, line_cnt=2. The same line with addr `00001009` → format_type=11, err_code=3, line_cnt unchanged.
- `^5@00003008: $40 <= 00000001#` → 11, err_code=1. `^9@00003008: $3 <= 00000001#` after a good time-12 line → 11, err_code=4. Repeat with CHECK_TIME=0 → 01.
- Malformed lines, each → format_type stays 00, FSM returns to IDLE, line_cnt unchanged:
  - `^12345@...` (5-digit time)
  - `^1@0000300:` (7 hex digits)
  - `^1@0000300A: ...` with ALLOW_UPPER=0
  - a missing `=`
- Recovery: `^1@00^2@00003000: $1 <= 00000000#` → only the second line is accepted (01). `#` followed immediately by `^` shows one cycle of 01, then the next line parses normally.
- Assert reset low mid-DATA and check outputs 0 without a clock edge. Then preset line_cnt near 2^CNT_W-1 (CNT_W=2) and feed 5 good lines → line_cnt saturates at 3.
